// File: rtl/bsg_axil_pkg.sv
// bsg_axil_pkg
//   AXI-Lite response codes and the CSR/FIFO address map. The DPI-side
//   driver uses the same offsets, so keep the two in step.
//   decode_word() classifies a word address (byte address >> 2).
package bsg_axil_pkg;

  localparam logic [1:0] resp_okay_c   = 2'b00;
  localparam logic [1:0] resp_slverr_c = 2'b10;

  // CSR k sits at byte offset 4*k starting from zero.
  localparam logic [31:0] pl2ps_data_addr_c = 32'h100;  // read pops
  localparam logic [31:0] pl2ps_cnt_addr_c  = 32'h104;  // occupancy, read-only
  localparam logic [31:0] ps2pl_data_addr_c = 32'h108;  // write pushes
  localparam logic [31:0] ps2pl_free_addr_c = 32'h10C;  // free slots, read-only

  typedef enum logic [2:0] {
    addr_csr,
    addr_pl2ps_data,
    addr_pl2ps_cnt,
    addr_ps2pl_data,
    addr_ps2pl_free,
    addr_unmapped
  } addr_dec_e;

  function automatic addr_dec_e decode_word(input logic [29:0] word,
                                            input int unsigned num_regs);
    addr_dec_e dec;
    if (word < 30'(num_regs))                    dec = addr_csr;
    else if (word == pl2ps_data_addr_c[31:2])    dec = addr_pl2ps_data;
    else if (word == pl2ps_cnt_addr_c[31:2])     dec = addr_pl2ps_cnt;
    else if (word == ps2pl_data_addr_c[31:2])    dec = addr_ps2pl_data;
    else if (word == ps2pl_free_addr_c[31:2])    dec = addr_ps2pl_free;
    else                                         dec = addr_unmapped;
    return dec;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small
//   Small register-based FIFO with a locally tracked element count.
//   Ports: v_i/data_i enqueue (caller guarantees room or a same-cycle
//   dequeue), ready_o = not full, v_o/data_o head, yumi_i dequeues the head,
//   count_o current occupancy. Enqueue and dequeue in one cycle both apply,
//   also when full (the freed head slot is the one being written).
module bsg_fifo_1r1w_small #(
  parameter  int unsigned width_p  = 32,
  parameter  int unsigned els_p    = 4,
  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_q [els_p];
  logic [width_p-1:0]  mem_d [els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = (count_q != cnt_w_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (v_i) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (yumi_i) rptr_d = ptr_inc(rptr_q);
    if (v_i && !yumi_i)      count_d = count_q + cnt_w_lp'(1);
    else if (!v_i && yumi_i) count_d = count_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bsg_axil_csr_fifo_slave.sv
// bsg_axil_csr_fifo_slave
//   AXI-Lite slave exposing num_regs_p read/write CSRs plus two FIFOs:
//   PS2PL (AXI writes push, PL side pops with yumi) and PL2PS (PL side
//   enqueues, AXI reads pop). Occupancy / free-slot counts are readable.
//   Ports: AXI-Lite AW/W/B/AR/R channels on aclk_i / aresetn_i,
//   csr_data_o (all CSRs, CSR k in slice k), ps2pl_* and pl2ps_* streams.
module bsg_axil_csr_fifo_slave
  import bsg_axil_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned num_regs_p   = 4,
  parameter int unsigned fifo_els_p   = 4
) (
  input  logic                               aclk_i,
  input  logic                               aresetn_i,
  input  logic [addr_width_p-1:0]            awaddr_i,
  input  logic [2:0]                         awprot_i,
  input  logic                               awvalid_i,
  output logic                               awready_o,
  input  logic [data_width_p-1:0]            wdata_i,
  input  logic [data_width_p/8-1:0]          wstrb_i,
  input  logic                               wvalid_i,
  output logic                               wready_o,
  output logic [1:0]                         bresp_o,
  output logic                               bvalid_o,
  input  logic                               bready_i,
  input  logic [addr_width_p-1:0]            araddr_i,
  input  logic [2:0]                         arprot_i,
  input  logic                               arvalid_i,
  output logic                               arready_o,
  output logic [data_width_p-1:0]            rdata_o,
  output logic [1:0]                         rresp_o,
  output logic                               rvalid_o,
  input  logic                               rready_i,
  output logic [num_regs_p*data_width_p-1:0] csr_data_o,
  output logic [data_width_p-1:0]            ps2pl_data_o,
  output logic                               ps2pl_v_o,
  input  logic                               ps2pl_yumi_i,
  input  logic [data_width_p-1:0]            pl2ps_data_i,
  input  logic                               pl2ps_v_i,
  output logic                               pl2ps_ready_o
);

  localparam int unsigned strb_w_lp    = data_width_p / 8;
  localparam int unsigned cnt_w_lp     = $clog2(fifo_els_p + 1);
  localparam int unsigned csr_idx_w_lp = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;

  logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [addr_width_p-1:0]   awaddr_q, awaddr_d;
  logic [data_width_p-1:0]   wdata_q, wdata_d;
  logic [strb_w_lp-1:0]      wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
  logic [data_width_p-1:0]   rdata_q, rdata_d;
  logic [data_width_p-1:0]   csr_q [num_regs_p];
  logic [data_width_p-1:0]   csr_d [num_regs_p];

  logic [data_width_p-1:0]   wmask;
  logic [29:0]               wr_word, rd_word;
  logic [csr_idx_w_lp-1:0]   wr_idx, rd_idx;
  addr_dec_e                 wr_dec, rd_dec;
  logic                      commit, ar_accept, ps2pl_push, pl2ps_pop;
  logic                      ps2pl_ready, ps2pl_yumi, pl2ps_v;
  logic [data_width_p-1:0]   pl2ps_data;
  logic [cnt_w_lp-1:0]       ps2pl_count, pl2ps_count;
  logic                      unused_prot;

  assign unused_prot = ^{awprot_i, arprot_i};

  assign awready_o = ~aw_held_q;
  assign wready_o  = ~w_held_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = ~rvalid_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

  for (genvar k = 0; k < num_regs_p; k++) begin : g_csr_out
    assign csr_data_o[k*data_width_p +: data_width_p] = csr_q[k];
  end

  for (genvar b = 0; b < strb_w_lp; b++) begin : g_wmask
    assign wmask[8*b +: 8] = {8{wstrb_q[b]}};
  end

  assign wr_word    = 30'(awaddr_q >> 2);
  assign rd_word    = 30'(araddr_i >> 2);
  assign wr_idx     = wr_word[csr_idx_w_lp-1:0];
  assign rd_idx     = rd_word[csr_idx_w_lp-1:0];
  assign wr_dec     = decode_word(wr_word, num_regs_p);
  assign rd_dec     = decode_word(rd_word, num_regs_p);
  assign commit     = aw_held_q & w_held_q & ~bvalid_q;
  assign ar_accept  = arvalid_i & ~rvalid_q;
  assign ps2pl_yumi = ps2pl_yumi_i & ps2pl_v_o;

  // Write side: holding registers, commit, B response.
  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    csr_d      = csr_q;
    ps2pl_push = 1'b0;
    if (awvalid_i && !aw_held_q) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (wvalid_i && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (bvalid_q && bready_i) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = resp_slverr_c;
      case (wr_dec)
        addr_csr: begin
          csr_d[wr_idx] = (csr_q[wr_idx] & ~wmask) | (wdata_q & wmask);
          bresp_d       = resp_okay_c;
        end
        // A full FIFO still accepts the push when the PL side pops this cycle.
        addr_ps2pl_data: begin
          if (ps2pl_ready || ps2pl_yumi) begin
            ps2pl_push = 1'b1;
            bresp_d    = resp_okay_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Read side: AR accepted straight into the R registers (one-cycle latency).
  always_comb begin
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pl2ps_pop = 1'b0;
    if (rvalid_q && rready_i) rvalid_d = 1'b0;
    if (ar_accept) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = resp_okay_c;
      case (rd_dec)
        addr_csr: rdata_d = csr_q[rd_idx];
        addr_pl2ps_data: begin
          if (pl2ps_v) begin
            rdata_d   = pl2ps_data;
            pl2ps_pop = 1'b1;
          end else begin
            rresp_d = resp_slverr_c;
          end
        end
        addr_pl2ps_cnt:  rdata_d[cnt_w_lp-1:0] = pl2ps_count;
        addr_ps2pl_free: rdata_d[cnt_w_lp-1:0] = cnt_w_lp'(fifo_els_p) - ps2pl_count;
        default:         rresp_d = resp_slverr_c;
      endcase
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= resp_okay_c;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= resp_okay_c;
      for (int k = 0; k < num_regs_p; k++) csr_q[k] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      csr_q     <= csr_d;
    end
  end

  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(fifo_els_p)) u_ps2pl (
    .clk_i     (aclk_i),
    .reset_n_i (aresetn_i),
    .v_i       (ps2pl_push),
    .data_i    (wdata_q),
    .ready_o   (ps2pl_ready),
    .v_o       (ps2pl_v_o),
    .data_o    (ps2pl_data_o),
    .yumi_i    (ps2pl_yumi),
    .count_o   (ps2pl_count)
  );

  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(fifo_els_p)) u_pl2ps (
    .clk_i     (aclk_i),
    .reset_n_i (aresetn_i),
    .v_i       (pl2ps_v_i & pl2ps_ready_o),
    .data_i    (pl2ps_data_i),
    .ready_o   (pl2ps_ready_o),
    .v_o       (pl2ps_v),
    .data_o    (pl2ps_data),
    .yumi_i    (pl2ps_pop),
    .count_o   (pl2ps_count)
  );

endmodule

// File: tb/tb_bsg_axil_csr_fifo_slave.sv
// Bench for bsg_axil_csr_fifo_slave: directed scenarios then randomized
// traffic, checked against a model built from an array of CSRs and two queues.
module tb_bsg_axil_csr_fifo_slave;

  localparam int NREGS    = 4;
  localparam int FIFO_ELS = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         aclk = 1'b0;
  logic         aresetn_i;
  logic [9:0]   awaddr_i, araddr_i;
  logic [2:0]   awprot_i, arprot_i;
  logic         awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;
  logic         awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  logic [31:0]  wdata_i, rdata_o;
  logic [3:0]   wstrb_i;
  logic [1:0]   bresp_o, rresp_o;
  logic [127:0] csr_data_o;
  logic [31:0]  ps2pl_data_o, pl2ps_data_i;
  logic         ps2pl_v_o, ps2pl_yumi_i, pl2ps_v_i, pl2ps_ready_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] csr_m [NREGS];
  logic [31:0] ps2pl_q [$];
  logic [31:0] pl2ps_q [$];

  always #5 aclk = ~aclk;

  bsg_axil_csr_fifo_slave dut (
    .aclk_i        (aclk),
    .aresetn_i     (aresetn_i),
    .awaddr_i      (awaddr_i),
    .awprot_i      (awprot_i),
    .awvalid_i     (awvalid_i),
    .awready_o     (awready_o),
    .wdata_i       (wdata_i),
    .wstrb_i       (wstrb_i),
    .wvalid_i      (wvalid_i),
    .wready_o      (wready_o),
    .bresp_o       (bresp_o),
    .bvalid_o      (bvalid_o),
    .bready_i      (bready_i),
    .araddr_i      (araddr_i),
    .arprot_i      (arprot_i),
    .arvalid_i     (arvalid_i),
    .arready_o     (arready_o),
    .rdata_o       (rdata_o),
    .rresp_o       (rresp_o),
    .rvalid_o      (rvalid_o),
    .rready_i      (rready_i),
    .csr_data_o    (csr_data_o),
    .ps2pl_data_o  (ps2pl_data_o),
    .ps2pl_v_o     (ps2pl_v_o),
    .ps2pl_yumi_i  (ps2pl_yumi_i),
    .pl2ps_data_i  (pl2ps_data_i),
    .pl2ps_v_i     (pl2ps_v_i),
    .pl2ps_ready_o (pl2ps_ready_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: write takes effect at commit; an optional same-cycle PL pop goes first.
  function automatic logic [1:0] model_write(input logic [9:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb, input bit yumi);
    int unsigned word = addr >> 2;
    if (yumi) void'(ps2pl_q.pop_front());
    if (word < NREGS) begin
      for (int b = 0; b < 4; b++) if (strb[b]) csr_m[word][8*b +: 8] = data[8*b +: 8];
      return OKAY;
    end
    if (word == 'h42) begin
      if (ps2pl_q.size() < FIFO_ELS) begin
        ps2pl_q.push_back(data);
        return OKAY;
      end
      return SLVERR;
    end
    return SLVERR;
  endfunction

  function automatic void model_read(input logic [9:0] addr, output logic [31:0] d,
                                     output logic [1:0] r);
    int unsigned word = addr >> 2;
    d = '0;
    r = OKAY;
    if (word < NREGS) d = csr_m[word];
    else if (word == 'h40) begin
      if (pl2ps_q.size() > 0) d = pl2ps_q.pop_front();
      else r = SLVERR;
    end
    else if (word == 'h41) d = pl2ps_q.size();
    else if (word == 'h43) d = FIFO_ELS - ps2pl_q.size();
    else r = SLVERR;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NREGS; k++) csr_m[k] = '0;
    ps2pl_q.delete();
    pl2ps_q.delete();
  endfunction

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input bit yumi, output logic [1:0] resp);
    logic [1:0] exp_resp;
    awaddr_i = addr;
    wdata_i  = data;
    wstrb_i  = strb;
    if (w_lead > 0) begin
      wvalid_i = 1'b1;
      @(posedge aclk); #1;
      wvalid_i = 1'b0;
      for (int i = 1; i < w_lead; i++) begin
        check_eq("w_only_no_b", bvalid_o, 1'b0);
        @(posedge aclk); #1;
      end
      check_eq("w_held_ready", wready_o, 1'b0);
      awvalid_i = 1'b1;
    end else begin
      awvalid_i = 1'b1;
      wvalid_i  = 1'b1;
    end
    @(posedge aclk); #1;
    awvalid_i = 1'b0;
    wvalid_i  = 1'b0;
    check_eq("b_not_early", bvalid_o, 1'b0);
    if (yumi) begin
      check_eq("yumi_head", ps2pl_data_o, ps2pl_q[0]);
      ps2pl_yumi_i = 1'b1;
    end
    exp_resp = model_write(addr, data, strb, yumi);
    @(posedge aclk); #1;
    ps2pl_yumi_i = 1'b0;
    check_eq("b_latency", bvalid_o, 1'b1);
    check_eq("bresp", bresp_o, exp_resp);
    resp = bresp_o;
    repeat ($urandom_range(0, 2)) begin
      @(posedge aclk); #1;
      check_eq("b_hold", {bvalid_o, bresp_o}, {1'b1, exp_resp});
    end
    bready_i = 1'b1;
    @(posedge aclk); #1;
    bready_i = 1'b0;
    check_eq("b_done", bvalid_o, 1'b0);
  endtask

  task automatic do_read(input logic [9:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    model_read(addr, exp_d, exp_r);
    check_eq("ar_ready", arready_o, 1'b1);
    araddr_i  = addr;
    arvalid_i = 1'b1;
    @(posedge aclk); #1;
    arvalid_i = 1'b0;
    check_eq("r_latency", rvalid_o, 1'b1);
    repeat ($urandom_range(0, 2)) begin
      check_eq("r_hold", {rvalid_o, rresp_o, rdata_o}, {1'b1, exp_r, exp_d});
      @(posedge aclk); #1;
    end
    check_eq("rdata", rdata_o, exp_d);
    check_eq("rresp", rresp_o, exp_r);
    d = rdata_o;
    r = rresp_o;
    rready_i = 1'b1;
    @(posedge aclk); #1;
    rready_i = 1'b0;
    check_eq("r_done", rvalid_o, 1'b0);
  endtask

  task automatic pl_enq(input logic [31:0] d);
    check_eq("pl2ps_ready", pl2ps_ready_o, pl2ps_q.size() < FIFO_ELS);
    pl2ps_data_i = d;
    pl2ps_v_i    = 1'b1;
    @(posedge aclk); #1;
    pl2ps_v_i = 1'b0;
    if (pl2ps_q.size() < FIFO_ELS) pl2ps_q.push_back(d);
  endtask

  task automatic ps_yumi();
    check_eq("ps2pl_v", ps2pl_v_o, ps2pl_q.size() > 0);
    if (ps2pl_q.size() > 0) begin
      check_eq("ps2pl_head", ps2pl_data_o, ps2pl_q[0]);
      ps2pl_yumi_i = 1'b1;
      @(posedge aclk); #1;
      ps2pl_yumi_i = 1'b0;
      void'(ps2pl_q.pop_front());
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < NREGS; k++) check_eq("csr_data_o", csr_data_o[k*32 +: 32], csr_m[k]);
    check_eq("ps2pl_v_o", ps2pl_v_o, ps2pl_q.size() != 0);
    check_eq("pl2ps_ready_o", pl2ps_ready_o, pl2ps_q.size() < FIFO_ELS);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_bvalid"}, bvalid_o, 1'b0);
    check_eq({tag, "_rvalid"}, rvalid_o, 1'b0);
    check_eq({tag, "_awready"}, awready_o, 1'b1);
    check_eq({tag, "_wready"}, wready_o, 1'b1);
    check_eq({tag, "_resp_data"}, {bresp_o, rresp_o, rdata_o}, 36'h0);
    check_eq({tag, "_csr_lo"}, csr_data_o[63:0], 64'h0);
    check_eq({tag, "_csr_hi"}, csr_data_o[127:64], 64'h0);
    check_eq({tag, "_ps2pl_v"}, ps2pl_v_o, 1'b0);
    check_eq({tag, "_pl2ps_ready"}, pl2ps_ready_o, 1'b1);
  endtask

  logic [9:0] rd_addrs [10] = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h100,
                                10'h104, 10'h10C, 10'h010, 10'h200, 10'h3F0};
  logic [9:0] bad_waddrs [6] = '{10'h100, 10'h104, 10'h10C, 10'h010, 10'h200, 10'h3FC};

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [9:0]  a;
    logic [31:0] old;

    aresetn_i = 1'b0;
    {awaddr_i, araddr_i, awprot_i, arprot_i} = '0;
    {awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i} = '0;
    wdata_i = '0; wstrb_i = '0;
    ps2pl_yumi_i = 1'b0; pl2ps_v_i = 1'b0; pl2ps_data_i = '0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("rst");
    aresetn_i = 1'b1;
    @(posedge aclk); #1;

    // CSR1 full write then byte-0 strobe write.
    do_write(10'h004, 32'hDEADBEEF, 4'hF, 0, 1'b0, r);
    check_eq("csr1_w1_resp", r, OKAY);
    do_write(10'h004, 32'h00000011, 4'h1, 0, 1'b0, r);
    do_read(10'h004, d, r);
    check_eq("csr1_strobe_data", d, 32'hDEADBE11);
    check_eq("csr1_slice", csr_data_o[63:32], 32'hDEADBE11);

    // W leads AW by three cycles: single commit, no extra B.
    do_write(10'h008, 32'hCAFE0002, 4'hF, 3, 1'b0, r);
    repeat (3) begin
      check_eq("no_second_b", bvalid_o, 1'b0);
      check_eq("holds_clear", {awready_o, wready_o}, 2'b11);
      @(posedge aclk); #1;
    end
    check_state();

    // Simultaneous read and write to CSR3: read sees the old value.
    do_write(10'h00C, 32'h12345678, 4'hF, 0, 1'b0, r);
    old = csr_m[3];
    awaddr_i = 10'h00C; wdata_i = 32'h87654321; wstrb_i = 4'hF;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    @(posedge aclk); #1;
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    araddr_i = 10'h00C; arvalid_i = 1'b1;
    @(posedge aclk); #1;
    arvalid_i = 1'b0;
    check_eq("rw_same_rvalid", {rvalid_o, bvalid_o}, 2'b11);
    check_eq("rw_same_rdata", rdata_o, old);
    check_eq("rw_same_bresp", bresp_o, OKAY);
    void'(model_write(10'h00C, 32'h87654321, 4'hF, 1'b0));
    check_eq("rw_same_csr3", csr_data_o[127:96], 32'h87654321);
    bready_i = 1'b1; rready_i = 1'b1;
    @(posedge aclk); #1;
    bready_i = 1'b0; rready_i = 1'b0;
    check_eq("rw_same_done", {rvalid_o, bvalid_o}, 2'b00);

    // PS2PL: five pushes into a 4-deep FIFO, then push-while-full with yumi.
    for (int i = 0; i < 5; i++) begin
      do_write(10'h108, 32'h100 + i, 4'h0, 0, 1'b0, r);
      check_eq("push_resp", r, (i < 4) ? OKAY : SLVERR);
    end
    do_read(10'h10C, d, r);
    check_eq("free_when_full", d, 32'd0);
    do_write(10'h108, 32'h0000F00D, 4'h3, 0, 1'b1, r);
    check_eq("push_full_yumi", r, OKAY);
    repeat (4) ps_yumi();
    do_read(10'h10C, d, r);
    check_eq("free_when_empty", d, 32'd4);

    // PL2PS: two entries, three popping reads.
    pl_enq(32'hA);
    pl_enq(32'hB);
    do_read(10'h104, d, r);
    check_eq("pl2ps_occ", d, 32'd2);
    do_read(10'h100, d, r);
    check_eq("pop0", {r, d}, {OKAY, 32'hA});
    do_read(10'h100, d, r);
    check_eq("pop1", {r, d}, {OKAY, 32'hB});
    do_read(10'h100, d, r);
    check_eq("pop_empty", {r, d}, {SLVERR, 32'h0});

    // Unmapped read and read-only write.
    do_read(10'h200, d, r);
    check_eq("unmapped_rd", r, SLVERR);
    do_write(10'h104, 32'hFFFFFFFF, 4'hF, 0, 1'b0, r);
    check_eq("ro_write", r, SLVERR);
    do_read(10'h104, d, r);
    check_eq("ro_write_no_change", d, 32'd0);
    check_state();

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          a = 10'(($urandom_range(0, NREGS - 1) << 2) | $urandom_range(0, 3));
          do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0, r);
        end
        1: do_write(10'(10'h108 | $urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 2), (ps2pl_q.size() > 0) && ($urandom_range(0, 1) == 1), r);
        2: do_write(bad_waddrs[$urandom_range(0, 5)], $urandom, 4'hF, 0, 1'b0, r);
        3: do_read(rd_addrs[$urandom_range(0, 9)], d, r);
        4: pl_enq($urandom);
        default: ps_yumi();
      endcase
      check_state();
    end

    // Reset during a stalled read with an AW also held.
    pl_enq(32'h55);
    do_write(10'h108, 32'h66, 4'hF, 0, 1'b0, r);
    awaddr_i = 10'h000; awvalid_i = 1'b1;
    araddr_i = 10'h000; arvalid_i = 1'b1;
    @(posedge aclk); #1;
    awvalid_i = 1'b0; arvalid_i = 1'b0;
    repeat (5) begin
      check_eq("r_stall", rvalid_o, 1'b1);
      @(posedge aclk); #1;
    end
    aresetn_i = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge aclk); #1;
    aresetn_i = 1'b1;
    model_reset();
    repeat (4) begin
      check_eq("post_rst_quiet", {rvalid_o, bvalid_o, awready_o, wready_o}, 4'b0011);
      @(posedge aclk); #1;
    end
    check_state();
    do_read(10'h004, d, r);
    do_read(10'h104, d, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_axil_csr_fifo_slave.md
BSG_AXIL_CSR_FIFO_SLAVE -- requirements
Module: bsg_axil_csr_fifo_slave

Interface
REQ-001 Parameters SHALL be: addr_width_p, default 10, byte-address width; data_width_p, default 32, data width; num_regs_p, default 4, number of CSRs; fifo_els_p, default 4, depth of each FIFO.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset: aclk_i in 1, sole clock; aresetn_i in 1, asynchronous active-low reset.
REQ-003 Write-address ports: awaddr_i in addr_width_p; awprot_i in 3, ignored; awvalid_i in 1; awready_o out 1.
REQ-004 Write-data ports: wdata_i in data_width_p; wstrb_i in data_width_p/8; wvalid_i in 1; wready_o out 1.
REQ-005 Write-response ports: bresp_o out 2; bvalid_o out 1; bready_i in 1.
REQ-006 Read-address ports: araddr_i in addr_width_p; arprot_i in 3, ignored; arvalid_i in 1; arready_o out 1.
REQ-007 Read-data ports: rdata_o out data_width_p; rresp_o out 2; rvalid_o out 1; rready_i in 1.
REQ-008 Register ports: csr_data_o out num_regs_p*data_width_p, current CSR contents.
REQ-009 FIFO ports: ps2pl_data_o out data_width_p, ps2pl_v_o out 1, ps2pl_yumi_i in 1 (PS-to-PL path); pl2ps_data_i in data_width_p, pl2ps_v_i in 1, pl2ps_ready_o out 1 (PL-to-PS path).

Function
REQ-010 Address map (byte offsets, word-aligned; bits [1:0] ignored):
- 0x000+4k, k<num_regs_p: CSR k, read/write.
- 0x100: PL2PS data; a read pops.
- 0x104: PL2PS occupancy; read-only.
- 0x108: PS2PL data; a write pushes.
- 0x10C: PS2PL free slots; read-only.
REQ-011 AW and W SHALL each be captured in a one-entry holding register: awready_o=~aw_held, wready_o=~w_held; the channels may arrive in any order or in the same cycle.
REQ-012 A write SHALL commit in the cycle where both registers are held and bvalid_o=0; bvalid_o SHALL assert on the next edge, and both holding registers SHALL clear on that same edge.
REQ-013 bvalid_o SHALL stay high, with bresp_o stable, until bready_i is high; no new write commits while bvalid_o=1.
REQ-014 A CSR write SHALL apply wstrb_i per byte; a PS2PL push SHALL ignore wstrb_i.
REQ-015 arready_o SHALL equal ~rvalid_o; on AR acceptance, rdata_o and rresp_o SHALL be registered and rvalid_o SHALL assert on the next edge, giving one-cycle latency; they SHALL hold until rready_i is high.
REQ-016 Responses SHALL be OKAY=2'b00 and SLVERR=2'b10.
- SLVERR cases: unmapped address; write to a read-only offset; push to a full PS2PL FIFO (data dropped); read of an empty PL2PS FIFO (rdata_o=0, no pop).
- An erroneous write SHALL change no state.
REQ-017 Occupancy and free-slot reads SHALL be zero-extended counts in 0..fifo_els_p, sampled in the AR-acceptance cycle.
REQ-018 pl2ps_ready_o SHALL be ~full; an enqueue and a pop in the same cycle SHALL both take effect, and a read pop SHALL return the pre-cycle head.
REQ-019 ps2pl_v_o SHALL be ~empty; ps2pl_data_o SHALL be the head; ps2pl_yumi_i SHALL only be asserted while ps2pl_v_o=1; an AXI push and a yumi in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-020 Read and write channels SHALL be independent; in a simultaneous CSR read and write to the same CSR, the read SHALL return the pre-write value.

Reset
REQ-021 While aresetn_i=0: bvalid_o=0, rvalid_o=0, awready_o=1, wready_o=1, rdata_o=0, bresp_o=0, rresp_o=0, all CSRs=0, both FIFOs empty (ps2pl_v_o=0, pl2ps_ready_o=1).
REQ-022 Reset asserted mid-transaction SHALL discard all held and outstanding transfers; no response SHALL be issued for them after reset is released.

Structure
REQ-023 A shared package bsg_axil_pkg SHALL hold the response codes and the address-map offset constants, so the same map is used by the DPI-side C++ driver and the RTL.
REQ-024 Each FIFO SHALL be an instance of one sub-module, bsg_fifo_1r1w_small, with a count tracked locally; there SHALL be no other sub-modules.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Write CSR1=0xDEADBEEF with wstrb=0xF, then wstrb=0x1 with data 0x11 -> read 0x004 returns 0xDEADBE11, OKAY; csr_data_o slice 1 matches.
- W presented 3 cycles before AW -> exactly one commit; bvalid_o high 1 cycle after both are held.
- Five pushes to 0x108 with fifo_els_p=4 and yumi held low -> first four OKAY, fifth SLVERR; 0x10C reads 0.
- PL2PS: enqueue 0xA, 0xB; read 0x100 three times -> 0xA OKAY, 0xB OKAY, 0 SLVERR.
- Read 0x200 and write 0x104 -> SLVERR on both, no state change.
- rready_i held low 5 cycles, then reset pulsed -> rvalid_o=0 after reset and no stale response appears.
